// File: rtl/const_record_scanner.sv
// Steps an index through a constant-record lookup table and waits a settle delay before each capture.
// It folds each returned hex/aval pair into running XOR, sum and last-value results.
module const_record_scanner #(
    parameter int N_ENTRIES = 4,
    parameter int SETTLE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] sel,
    input  logic [7:0]  hex,
    input  logic [7:0]  aval,
    output logic        busy,
    output logic        done,
    output logic [7:0]  hex_xor,
    output logic [15:0] aval_sum,
    output logic [7:0]  last_hex,
    output logic [7:0]  last_aval,
    output logic [8:0]  entry_count
);

    localparam int             IW          = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam logic [IW-1:0]  LAST_IDX    = IW'(N_ENTRIES - 1);
    localparam logic [3:0]     SETTLE_INIT = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    hex_xor_q, hex_xor_d;
    logic [15:0]   aval_sum_q, aval_sum_d;
    logic [7:0]    last_hex_q, last_hex_d;
    logic [7:0]    last_aval_q, last_aval_d;
    logic [8:0]    count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            hex_xor_q   <= '0;
            aval_sum_q  <= '0;
            last_hex_q  <= '0;
            last_aval_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            hex_xor_q   <= hex_xor_d;
            aval_sum_q  <= aval_sum_d;
            last_hex_q  <= last_hex_d;
            last_aval_q <= last_aval_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        hex_xor_d   = hex_xor_q;
        aval_sum_d  = aval_sum_q;
        last_hex_d  = last_hex_q;
        last_aval_d = last_aval_q;
        count_d     = count_q;

        unique case (state_q)
            ST_IDLE: begin
                // Abort takes priority over start, so both together leave the scanner idle.
                if (start && !abort) begin
                    sel_d       = '0;
                    cnt_d       = SETTLE_INIT;
                    hex_xor_d   = '0;
                    aval_sum_d  = '0;
                    last_hex_d  = '0;
                    last_aval_d = '0;
                    count_d     = '0;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    hex_xor_d   = hex_xor_q ^ hex;
                    aval_sum_d  = aval_sum_q + {8'h00, aval};
                    last_hex_d  = hex;
                    last_aval_d = aval;
                    count_d     = count_q + 9'd1;
                    if (sel_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        sel_d   = sel_q + 1'b1;
                        cnt_d   = SETTLE_INIT;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel         = 32'(sel_q);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign hex_xor     = hex_xor_q;
    assign aval_sum    = aval_sum_q;
    assign last_hex    = last_hex_q;
    assign last_aval   = last_aval_q;
    assign entry_count = count_q;

endmodule
